// File: rtl/frame_generator_xn.sv
// frame_generator_xn: parametrised PHY transmit framer.
// Ordered sets are sent in parallel on every lane, with a repeat count.
// TLP/DLLP beats are byte-striped with STP/SDP start framing, END/EDB tail
// framing and PAD fill. All outputs except pkt_ready are registered.
//
// Handshake: an OS request transfers on a rising edge where os_req & os_ready,
// and a packet beat transfers where pkt_valid & pkt_ready. The source holds
// request/beat and its qualifiers stable until the transfer. pkt_ready is a
// registered ready flag gated combinationally by framer_en and by a
// same-cycle OS transfer, so that an OS always wins arbitration in IDLE.
module frame_generator_xn #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               os_req,
  input  logic [2:0]         os_type,
  input  logic [39:0]        os_fields,
  input  logic [CNT_W-1:0]   os_count,
  output logic               os_ready,
  output logic               os_done,
  output logic               err_os,
  input  logic               framer_en,
  input  logic               pkt_valid,
  input  logic               pkt_type,
  input  logic [8*LANES-1:0] pkt_data,
  input  logic               pkt_last,
  input  logic               pkt_nullify,
  output logic               pkt_ready,
  output logic               err_pkt,
  output logic [8*LANES-1:0] tx_data,
  output logic [LANES-1:0]   tx_k,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OS   = 2'd1;
  localparam logic [1:0] ST_PKT  = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  localparam logic [2:0] OS_TS1   = 3'd1;
  localparam logic [2:0] OS_TS2   = 3'd2;
  localparam logic [2:0] OS_EIOS  = 3'd3;
  localparam logic [2:0] OS_EIEOS = 3'd4;
  localparam logic [2:0] OS_FTS   = 3'd5;

  localparam logic [7:0] SYM_COM   = 8'hBC;
  localparam logic [7:0] SYM_STP   = 8'hFB;
  localparam logic [7:0] SYM_SDP   = 8'h5C;
  localparam logic [7:0] SYM_END   = 8'hFD;
  localparam logic [7:0] SYM_EDB   = 8'hFE;
  localparam logic [7:0] SYM_PAD   = 8'hF7;
  localparam logic [7:0] SYM_IDL   = 8'h7C;
  localparam logic [7:0] SYM_FTS   = 8'h3C;
  localparam logic [7:0] SYM_EIE   = 8'hFC;
  localparam logic [7:0] SYM_D10_2 = 8'h4A;
  localparam logic [7:0] SYM_D5_2  = 8'h45;

  logic [1:0]         state, state_nxt;
  logic [2:0]         os_type_q, os_type_nxt;
  logic [39:0]        os_fields_q, os_fields_nxt;
  logic [3:0]         sym_idx, sym_idx_nxt;
  logic [CNT_W-1:0]   rep_left, rep_left_nxt;
  logic [7:0]         carry, carry_nxt;
  logic               nullify_q, nullify_nxt;
  logic               pkt_ready_q;
  logic [8*LANES-1:0] tx_data_nxt;
  logic [LANES-1:0]   tx_k_nxt;
  logic               os_done_nxt, err_os_nxt, err_pkt_nxt;

  logic               os_fire, pkt_fire, os_req_legal, os_is_ts;
  logic [3:0]         os_last_idx;
  logic [7:0]         os_sym, tail_end, beat_lane0;
  logic               os_sym_k;
  logic [8*LANES-1:0] os_data, tail_data, pad_data, beat_data;
  logic [LANES-1:0]   os_k, tail_k;

  assign os_fire      = os_req & os_ready;
  assign pkt_ready    = pkt_ready_q & framer_en & ~os_fire;
  assign pkt_fire     = pkt_valid & pkt_ready;
  assign os_req_legal = (os_type >= OS_TS1) && (os_type <= OS_FTS) && (os_count != '0);
  assign os_is_ts     = (os_type_q == OS_TS1) || (os_type_q == OS_TS2);
  assign state_dbg    = state;
  // Lane 0 of a beat is the start symbol on the first beat, else the carried byte.
  assign beat_lane0   = (state == ST_IDLE) ? (pkt_type ? SYM_SDP : SYM_STP) : carry;
  assign beat_data    = {pkt_data[8*LANES-9:0], beat_lane0};
  // An abort (tail emitted straight from PKT) always ends with EDB.
  assign tail_end     = (state == ST_TAIL && !nullify_q) ? SYM_END : SYM_EDB;

  // Common symbol for the current ordered-set index, plus the last index of a repetition.
  always_comb begin
    os_sym      = 8'h00;
    os_sym_k    = 1'b0;
    os_last_idx = 4'd15;
    case (os_type_q)
      OS_TS1, OS_TS2: begin
        case (sym_idx)
          4'd0: begin os_sym = SYM_COM; os_sym_k = 1'b1; end
          4'd1: os_sym = os_fields_q[39:32];
          4'd2: os_sym = os_fields_q[31:24];
          4'd3: os_sym = os_fields_q[23:16];
          4'd4: os_sym = os_fields_q[15:8];
          4'd5: os_sym = os_fields_q[7:0];
          default: os_sym = (os_type_q == OS_TS1) ? SYM_D10_2 : SYM_D5_2;
        endcase
      end
      OS_EIOS: begin
        os_last_idx = 4'd3;
        os_sym      = (sym_idx == 4'd0) ? SYM_COM : SYM_IDL;
        os_sym_k    = 1'b1;
      end
      OS_FTS: begin
        os_last_idx = 4'd3;
        os_sym      = (sym_idx == 4'd0) ? SYM_COM : SYM_FTS;
        os_sym_k    = 1'b1;
      end
      default: begin
        // EIEOS: COM, 14 EIE, then one D10.2 data symbol.
        if (sym_idx == 4'd0) begin
          os_sym = SYM_COM; os_sym_k = 1'b1;
        end else if (sym_idx == 4'd15) begin
          os_sym = SYM_D10_2; os_sym_k = 1'b0;
        end else begin
          os_sym = SYM_EIE; os_sym_k = 1'b1;
        end
      end
    endcase
  end

  // Replicate the OS symbol on every lane; TS symbol 2 carries lane number + i.
  always_comb begin
    os_data = '0;
    os_k    = '0;
    for (int i = 0; i < LANES; i++) begin
      os_data[8*i +: 8] = os_sym;
      os_k[i]           = os_sym_k;
      if (os_is_ts && sym_idx == 4'd2) os_data[8*i +: 8] = os_fields_q[31:24] + 8'(i);
    end
  end

  // Tail (carry, END/EDB, PADs) and all-PAD stall vectors.
  always_comb begin
    tail_data = '0;
    tail_k    = '0;
    pad_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      pad_data[8*i +: 8] = SYM_PAD;
      if (i == 0) begin
        tail_data[8*i +: 8] = carry;
      end else if (i == 1) begin
        tail_data[8*i +: 8] = tail_end;
        tail_k[i]           = 1'b1;
      end else begin
        tail_data[8*i +: 8] = SYM_PAD;
        tail_k[i]           = 1'b1;
      end
    end
  end

  // Next-state and next-output logic of the framer FSM.
  always_comb begin
    state_nxt     = state;
    os_type_nxt   = os_type_q;
    os_fields_nxt = os_fields_q;
    sym_idx_nxt   = sym_idx;
    rep_left_nxt  = rep_left;
    carry_nxt     = carry;
    nullify_nxt   = nullify_q;
    tx_data_nxt   = '0;
    tx_k_nxt      = '0;
    os_done_nxt   = 1'b0;
    err_os_nxt    = 1'b0;
    err_pkt_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (os_fire) begin
          if (!os_req_legal) begin
            err_os_nxt = 1'b1;
          end else begin
            os_type_nxt   = os_type;
            os_fields_nxt = os_fields;
            tx_data_nxt   = {LANES{SYM_COM}};
            tx_k_nxt      = '1;
            sym_idx_nxt   = 4'd1;
            rep_left_nxt  = os_count;
            state_nxt     = ST_OS;
          end
        end else if (pkt_fire) begin
          tx_data_nxt = beat_data;
          tx_k_nxt    = LANES'(1);
          carry_nxt   = pkt_data[8*LANES-1 -: 8];
          if (pkt_last) begin
            nullify_nxt = pkt_nullify;
            state_nxt   = ST_TAIL;
          end else begin
            state_nxt   = ST_PKT;
          end
        end
      end
      ST_OS: begin
        tx_data_nxt = os_data;
        tx_k_nxt    = os_k;
        if (sym_idx == os_last_idx) begin
          sym_idx_nxt = 4'd0;
          if (rep_left == CNT_W'(1)) begin
            os_done_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else begin
            rep_left_nxt = rep_left - CNT_W'(1);
          end
        end else begin
          sym_idx_nxt = sym_idx + 4'd1;
        end
      end
      ST_PKT: begin
        if (!framer_en) begin
          tx_data_nxt = tail_data;
          tx_k_nxt    = tail_k;
          err_pkt_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (pkt_fire) begin
          tx_data_nxt = beat_data;
          carry_nxt   = pkt_data[8*LANES-1 -: 8];
          if (pkt_last) begin
            nullify_nxt = pkt_nullify;
            state_nxt   = ST_TAIL;
          end
        end else begin
          tx_data_nxt = pad_data;
          tx_k_nxt    = '1;
        end
      end
      default: begin
        tx_data_nxt = tail_data;
        tx_k_nxt    = tail_k;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      os_type_q   <= OS_TS1;
      os_fields_q <= '0;
      sym_idx     <= '0;
      rep_left    <= '0;
      carry       <= '0;
      nullify_q   <= 1'b0;
      pkt_ready_q <= 1'b0;
      os_ready    <= 1'b0;
      os_done     <= 1'b0;
      err_os      <= 1'b0;
      err_pkt     <= 1'b0;
      tx_data     <= '0;
      tx_k        <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      os_type_q   <= os_type_nxt;
      os_fields_q <= os_fields_nxt;
      sym_idx     <= sym_idx_nxt;
      rep_left    <= rep_left_nxt;
      carry       <= carry_nxt;
      nullify_q   <= nullify_nxt;
      pkt_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_PKT);
      os_ready    <= (state_nxt == ST_IDLE);
      os_done     <= os_done_nxt;
      err_os      <= err_os_nxt;
      err_pkt     <= err_pkt_nxt;
      tx_data     <= tx_data_nxt;
      tx_k        <= tx_k_nxt;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_frame_generator_xn.sv
// Directed testbench for frame_generator_xn at LANES=4.
module tb_frame_generator_xn;
  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              os_req;
  logic [2:0]        os_type;
  logic [39:0]       os_fields;
  logic [CNT_W-1:0]  os_count;
  logic              os_ready, os_done, err_os;
  logic              framer_en, pkt_valid, pkt_type, pkt_last, pkt_nullify;
  logic [8*LANES-1:0] pkt_data;
  logic              pkt_ready, err_pkt, busy;
  logic [8*LANES-1:0] tx_data;
  logic [LANES-1:0]  tx_k;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] ts1_d [16];
  logic [3:0]  ts1_k [16];

  frame_generator_xn #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .os_req(os_req), .os_type(os_type), .os_fields(os_fields), .os_count(os_count),
    .os_ready(os_ready), .os_done(os_done), .err_os(err_os),
    .framer_en(framer_en), .pkt_valid(pkt_valid), .pkt_type(pkt_type),
    .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_nullify(pkt_nullify),
    .pkt_ready(pkt_ready), .err_pkt(err_pkt),
    .tx_data(tx_data), .tx_k(tx_k), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag, input logic [31:0] d, input logic [3:0] k);
    check({tag, "_data"}, 64'(tx_data), 64'(d));
    check({tag, "_k"}, 64'(tx_k), 64'(k));
  endtask

  initial begin
    // Expected TS1 symbols for fields {01,00,20,02,00}
    ts1_d[0] = 32'hBCBCBCBC; ts1_k[0] = 4'hF;
    ts1_d[1] = 32'h01010101; ts1_k[1] = 4'h0;
    ts1_d[2] = 32'h03020100; ts1_k[2] = 4'h0;
    ts1_d[3] = 32'h20202020; ts1_k[3] = 4'h0;
    ts1_d[4] = 32'h02020202; ts1_k[4] = 4'h0;
    ts1_d[5] = 32'h00000000; ts1_k[5] = 4'h0;
    for (int s = 6; s < 16; s++) begin ts1_d[s] = 32'h4A4A4A4A; ts1_k[s] = 4'h0; end

    rst = 1'b1; os_req = 1'b0; os_type = 3'd0; os_fields = '0; os_count = '0;
    framer_en = 1'b0; pkt_valid = 1'b0; pkt_type = 1'b0; pkt_data = '0;
    pkt_last = 1'b0; pkt_nullify = 1'b0;

    // Reset values
    next_cycle();
    next_cycle();
    check_tx("rst_tx", 32'h0, 4'h0);
    check("rst_os_ready", 64'(os_ready), 64'd0);
    check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    check("rst_os_done", 64'(os_done), 64'd0);
    check("rst_err_os", 64'(err_os), 64'd0);
    check("rst_err_pkt", 64'(err_pkt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1 check("rel_os_ready_lag", 64'(os_ready), 64'd0);
    next_cycle();
    check("rel_os_ready", 64'(os_ready), 64'd1);
    check("rel_pkt_ready_en0", 64'(pkt_ready), 64'd0);
    framer_en = 1'b1;
    #1 check("rel_pkt_ready_en1", 64'(pkt_ready), 64'd1);

    // TS1 x2
    os_req = 1'b1; os_type = 3'd1; os_fields = 40'h01_00_20_02_00; os_count = 16'd2;
    #1 check("ts1_arb_pkt_ready", 64'(pkt_ready), 64'd0);
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      if (c == 1) os_req = 1'b0;
      check_tx($sformatf("ts1_c%0d", c), ts1_d[(c-1) % 16], ts1_k[(c-1) % 16]);
      check($sformatf("ts1_done_c%0d", c), 64'(os_done), 64'(c == 32));
      if (c == 5) begin
        check("ts1_busy", 64'(busy), 64'd1);
        check("ts1_os_ready", 64'(os_ready), 64'd0);
        check("ts1_pkt_ready", 64'(pkt_ready), 64'd0);
      end
    end
    check("ts1_end_os_ready", 64'(os_ready), 64'd1);

    // EIOS x1 then FTS x3 back-to-back
    os_req = 1'b1; os_type = 3'd3; os_count = 16'd1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (c == 1) begin os_type = 3'd5; os_count = 16'd3; end
      if (c == 5) os_req = 1'b0;
      if (c <= 4)
        check_tx($sformatf("eios_c%0d", c), (c == 1) ? 32'hBCBCBCBC : 32'h7C7C7C7C, 4'hF);
      else
        check_tx($sformatf("fts_c%0d", c), ((c-5) % 4 == 0) ? 32'hBCBCBCBC : 32'h3C3C3C3C, 4'hF);
      check($sformatf("ef_done_c%0d", c), 64'(os_done), 64'((c == 4) || (c == 16)));
      check($sformatf("ef_os_ready_c%0d", c), 64'(os_ready), 64'((c == 4) || (c == 16)));
    end

    // TLP of 3 beats, bytes 01..0C
    pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 32'h04030201; pkt_last = 1'b0;
    #1 check("tlp_ready0", 64'(pkt_ready), 64'd1);
    next_cycle();
    check_tx("tlp_b0", 32'h030201FB, 4'b0001);
    check("tlp_busy", 64'(busy), 64'd1);
    pkt_data = 32'h08070605;
    next_cycle();
    check_tx("tlp_b1", 32'h07060504, 4'b0000);
    pkt_data = 32'h0C0B0A09; pkt_last = 1'b1;
    next_cycle();
    check_tx("tlp_b2", 32'h0B0A0908, 4'b0000);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    #1 check("tlp_tail_ready", 64'(pkt_ready), 64'd0);
    next_cycle();
    check_tx("tlp_tail", 32'hF7F7FD0C, 4'b1110);
    check("tlp_err_pkt", 64'(err_pkt), 64'd0);
    next_cycle();
    check_tx("tlp_idle", 32'h0, 4'h0);

    // DLLP of 2 beats, nullified
    pkt_valid = 1'b1; pkt_type = 1'b1; pkt_data = 32'h04030201;
    next_cycle();
    check_tx("dllp_b0", 32'h0302015C, 4'b0001);
    pkt_data = 32'h08070605; pkt_last = 1'b1; pkt_nullify = 1'b1;
    next_cycle();
    check_tx("dllp_b1", 32'h07060504, 4'b0000);
    pkt_valid = 1'b0; pkt_last = 1'b0; pkt_nullify = 1'b0;
    next_cycle();
    check_tx("dllp_tail", 32'hF7F7FE08, 4'b1110);
    next_cycle();

    // TLP with a stall, then framer_en dropped after beat 1
    pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 32'h14131211;
    next_cycle();
    check_tx("abt_b0", 32'h131211FB, 4'b0001);
    pkt_valid = 1'b0;
    next_cycle();
    check_tx("abt_stall", 32'hF7F7F7F7, 4'hF);
    pkt_valid = 1'b1; pkt_data = 32'h18171615;
    next_cycle();
    check_tx("abt_b1", 32'h17161514, 4'b0000);
    framer_en = 1'b0; pkt_data = 32'h1C1B1A19;
    #1 check("abt_ready", 64'(pkt_ready), 64'd0);
    next_cycle();
    check_tx("abt_tail", 32'hF7F7FE18, 4'b1110);
    check("abt_err_pkt", 64'(err_pkt), 64'd1);
    check("abt_busy", 64'(busy), 64'd0);
    pkt_valid = 1'b0;
    next_cycle();
    check("abt_err_pkt_clr", 64'(err_pkt), 64'd0);
    check_tx("abt_idle", 32'h0, 4'h0);
    framer_en = 1'b1;

    // Illegal OS requests
    os_req = 1'b1; os_type = 3'd6; os_count = 16'd1;
    next_cycle();
    check("ill_type_err", 64'(err_os), 64'd1);
    check_tx("ill_type_tx", 32'h0, 4'h0);
    check("ill_type_busy", 64'(busy), 64'd0);
    os_type = 3'd1; os_count = 16'd0;
    next_cycle();
    check("ill_cnt_err", 64'(err_os), 64'd1);
    check_tx("ill_cnt_tx", 32'h0, 4'h0);
    os_req = 1'b0;
    next_cycle();
    check("ill_err_clr", 64'(err_os), 64'd0);

    // Simultaneous OS and packet in IDLE: OS first
    os_req = 1'b1; os_type = 3'd3; os_count = 16'd1;
    pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 32'h24232221; pkt_last = 1'b1;
    #1 check("sim_pkt_ready", 64'(pkt_ready), 64'd0);
    next_cycle();
    os_req = 1'b0;
    check_tx("sim_com", 32'hBCBCBCBC, 4'hF);
    next_cycle();
    next_cycle();
    next_cycle();
    check_tx("sim_eios_last", 32'h7C7C7C7C, 4'hF);
    check("sim_done", 64'(os_done), 64'd1);
    check("sim_pkt_ready_after", 64'(pkt_ready), 64'd1);
    next_cycle();
    check_tx("sim_stp", 32'h232221FB, 4'b0001);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    next_cycle();
    check_tx("sim_tail", 32'hF7F7FD24, 4'b1110);

    // Reset in the middle of an ordered set
    os_req = 1'b1; os_type = 3'd1; os_count = 16'd1;
    next_cycle();
    os_req = 1'b0;
    next_cycle();
    next_cycle();
    check_tx("mid_ts1", 32'h03020100, 4'h0);
    rst = 1'b1;
    next_cycle();
    check_tx("mid_rst_tx", 32'h0, 4'h0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_os_ready", 64'(os_ready), 64'd0);
    check("mid_rst_pkt_ready", 64'(pkt_ready), 64'd0);
    rst = 1'b0;
    next_cycle();
    check("mid_rel_os_ready", 64'(os_ready), 64'd1);
    check_tx("mid_rel_tx", 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
